// File: rtl/trace_recorder_if.sv
// Ready/valid frame-word stream from trace_recorder (master) to the host (slave).
interface trace_recorder_if #(
    parameter int unsigned OUT_W = 32
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/trace_recorder.sv
// Captures timestamped sample vectors into a FIFO and streams them as stamp+chunk word frames.
// Optional TRACE_RECORDER_DEDUP_EN suppresses captures equal to the last pushed sample.
module trace_recorder #(
    parameter int unsigned SAMPLE_W = 96,
    parameter int unsigned OUT_W    = 32,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                record_en,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    trace_recorder_if.master    out,
    output logic [15:0]         dropped,
    output logic                overflow,
    output logic                empty
);
    localparam int unsigned NW   = (SAMPLE_W + OUT_W - 1) / OUT_W;
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned IdxW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [OUT_W-1:0]  cyc_q, cyc_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [15:0]       dropped_q, dropped_d;
    logic              overflow_q, overflow_d;
    logic              out_valid_q, out_valid_d;

    logic [OUT_W-1:0]    stamp_mem_q  [DEPTH];
    logic [SAMPLE_W-1:0] sample_mem_q [DEPTH];

    logic                capture, full, push, pop, is_new;
    logic [NW*OUT_W-1:0] head_padded;
    logic [OUT_W-1:0]    out_data_w;

`ifdef TRACE_RECORDER_DEDUP_EN
    logic [SAMPLE_W-1:0] last_q, last_d;
    logic                have_prev_q, have_prev_d;

    assign is_new = !have_prev_q || (sample != last_q);

    always_comb begin
        last_d      = last_q;
        have_prev_d = have_prev_q;
        if (push) begin
            last_d      = sample;
            have_prev_d = 1'b1;
        end
    end
`else
    assign is_new = 1'b1;
`endif

    always_comb begin
        capture = record_en && sample_valid && is_new;
        // Full is judged on registered occupancy, so a same-cycle pop cannot save the capture.
        full    = (count_q == CntW'(DEPTH));
        push    = capture && !full;
        pop     = (state_q == StData) && out.out_ready && (idx_q == IdxW'(NW - 1));

        cyc_d      = cyc_q + 1'b1;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CntW'(push) - CntW'(pop);
        overflow_d = overflow_q || (capture && full);
        dropped_d  = dropped_q;
        if (capture && full && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end

        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: if (count_q != '0) state_d = StHdr;
            StHdr: begin
                if (out.out_ready) begin
                    state_d = StData;
                    idx_d   = '0;
                end
            end
            StData: begin
                if (pop) begin
                    state_d = (count_d != '0) ? StHdr : StIdle;
                end else if (out.out_ready) begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        out_valid_d = (state_d != StIdle);
    end

    // Head entry is read in place; writes never target rd_ptr while it is occupied.
    always_comb begin
        head_padded                 = '0;
        head_padded[SAMPLE_W-1:0]   = sample_mem_q[rd_ptr_q];
        out_data_w                  = '0;
        if (state_q == StHdr) begin
            out_data_w = stamp_mem_q[rd_ptr_q];
        end else if (state_q == StData) begin
            for (int k = 0; k < int'(NW); k++) begin
                if (idx_q == IdxW'(k)) out_data_w = head_padded[k*OUT_W +: OUT_W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            cyc_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dropped_q   <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef TRACE_RECORDER_DEDUP_EN
            last_q      <= '0;
            have_prev_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cyc_q       <= cyc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dropped_q   <= dropped_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
`ifdef TRACE_RECORDER_DEDUP_EN
            last_q      <= last_d;
            have_prev_q <= have_prev_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            stamp_mem_q[wr_ptr_q]  <= cyc_q;
            sample_mem_q[wr_ptr_q] <= sample;
        end
    end

    assign out.out_valid = out_valid_q;
    assign out.out_data  = out_data_w;
    assign out.out_last  = (state_q == StData) && (idx_q == IdxW'(NW - 1));
    assign dropped       = dropped_q;
    assign overflow      = overflow_q;
    assign empty         = (count_q == '0) && (state_q == StIdle);
endmodule

// File: tb/tb_trace_recorder.sv
// Self-checking bench for trace_recorder: queue-based frame model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_trace_recorder;
    localparam int unsigned SAMPLE_W = 96;
    localparam int unsigned OUT_W    = 32;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned NW       = 3;

    typedef struct {
        logic [OUT_W-1:0]    stamp;
        logic [SAMPLE_W-1:0] smp;
    } entry_t;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             last;
    } word_t;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                record_en = 1'b0;
    logic                sample_valid = 1'b0;
    logic [SAMPLE_W-1:0] sample = '0;
    logic [15:0]         dropped;
    logic                overflow;
    logic                empty;

    trace_recorder_if #(.OUT_W(OUT_W)) bus ();

    trace_recorder #(
        .SAMPLE_W(SAMPLE_W),
        .OUT_W   (OUT_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .record_en   (record_en),
        .sample_valid(sample_valid),
        .sample      (sample),
        .out         (bus),
        .dropped     (dropped),
        .overflow    (overflow),
        .empty       (empty)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: list of pending captures plus a word position within the head frame.
    entry_t              m_q[$];
    logic [OUT_W-1:0]    m_cyc = '0;
    bit                  m_active = 1'b0;
    int                  m_pos = 0;
    int unsigned         m_dropped = 0;
    bit                  m_ovf = 1'b0;
    bit                  m_have_prev = 1'b0;
    logic [SAMPLE_W-1:0] m_last = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_cyc       = '0;
            m_active    = 1'b0;
            m_pos       = 0;
            m_dropped   = 0;
            m_ovf       = 1'b0;
            m_have_prev = 1'b0;
            m_last      = '0;
        end else begin
            int     occ;
            bit     cap;
            bit     pop;
            entry_t e;
            occ = m_q.size();
            cap = record_en && sample_valid;
`ifdef TRACE_RECORDER_DEDUP_EN
            if (m_have_prev && (sample == m_last)) cap = 1'b0;
`endif
            pop = m_active && bus.out_ready && (m_pos == int'(NW));
            if (cap) begin
                if (occ == int'(DEPTH)) begin
                    if (m_dropped < 65535) m_dropped++;
                    m_ovf = 1'b1;
                end else begin
                    e.stamp = m_cyc;
                    e.smp   = sample;
                    m_q.push_back(e);
                    m_have_prev = 1'b1;
                    m_last      = sample;
                end
            end
            if (pop) begin
                void'(m_q.pop_front());
                m_pos    = 0;
                m_active = (m_q.size() > 0);
            end else if (m_active && bus.out_ready) begin
                m_pos++;
            end else if (!m_active && occ > 0) begin
                m_active = 1'b1;
                m_pos    = 0;
            end
            m_cyc = m_cyc + 1'b1;
        end
    end

    function automatic logic [OUT_W-1:0] m_word();
        logic [SAMPLE_W-1:0] sh;
        if (!m_active || m_q.size() == 0) return '0;
        if (m_pos == 0) return m_q[0].stamp;
        sh = m_q[0].smp >> (OUT_W * (m_pos - 1));
        return sh[OUT_W-1:0];
    endfunction

    word_t log_q[$];
    int    acc_cyc[$];
    int    cyc_n = 0;

    always @(negedge clock) begin
        if (reset) begin
            chk("out_valid", bus.out_valid, m_active);
            if (m_active) chk("out_data", bus.out_data, m_word());
            chk("out_last", bus.out_last, m_active && (m_pos == int'(NW)));
            chk("dropped", dropped, m_dropped);
            chk("overflow", overflow, m_ovf);
            chk("empty", empty, (m_q.size() == 0) && !m_active);
            if (bus.out_valid && bus.out_ready) begin
                word_t w;
                w.data = bus.out_data;
                w.last = bus.out_last;
                log_q.push_back(w);
                acc_cyc.push_back(cyc_n);
            end
            cyc_n++;
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        record_en     = 1'b0;
        sample_valid  = 1'b0;
        sample        = '0;
        bus.out_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_data", bus.out_data, 32'h0);
        chk("rst_last", bus.out_last, 1'b0);
        chk("rst_dropped", dropped, 16'h0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_empty", empty, 1'b1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        log_q.delete();
        acc_cyc.delete();
    endtask

    task automatic cap(input logic [SAMPLE_W-1:0] s);
        record_en    = 1'b1;
        sample_valid = 1'b1;
        sample       = s;
        step();
        record_en    = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        bus.out_ready = 1'b1;
        for (int i = 0; i < budget && !empty; i++) step();
        chk("drain_empty", empty, 1'b1);
    endtask

    function automatic int frames();
        int n = 0;
        foreach (log_q[i]) if (log_q[i].last) n++;
        return n;
    endfunction

    function automatic logic [SAMPLE_W-1:0] rnd_sample();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SAMPLE_W-1:0] sa, sb, sc;
        logic [OUT_W-1:0]    exp_w[4];
        logic                exp_l[4];

        // Single capture at stamp 5.
        do_reset();
        bus.out_ready = 1'b1;
        repeat (5) step();
        cap(96'h0000_0003_0000_0002_0000_0001);
        drain(50);
        exp_w = '{32'h5, 32'h1, 32'h2, 32'h3};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        chk("single_len", log_q.size(), 4);
        if (log_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("single_w%0d", i), log_q[i].data, exp_w[i]);
                chk($sformatf("single_l%0d", i), log_q[i].last, exp_l[i]);
            end
        end

        // Backpressure while chunk 1 is presented.
        do_reset();
        bus.out_ready = 1'b1;
        cap(96'hCCCC_CCCC_BBBB_BBBB_AAAA_AAAA);
        for (int i = 0; i < 20 && log_q.size() < 2; i++) step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", bus.out_valid, 1'b1);
            chk("bp_data", bus.out_data, 32'hBBBB_BBBB);
        end
        drain(50);
        exp_w = '{32'h0, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC};
        chk("bp_len", log_q.size(), 4);
        if (log_q.size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("bp_w%0d", i), log_q[i].data, exp_w[i]);
        end

        // Overflow: 10 captures into an 8-deep FIFO with the host stalled.
        do_reset();
        for (int i = 0; i < 10; i++) cap(rnd_sample());
        chk("ovf_dropped", dropped, 16'd2);
        chk("ovf_flag", overflow, 1'b1);
        drain(200);
        chk("ovf_frames", frames(), 8);
        if (log_q.size() == 32) begin
            for (int k = 0; k < 8; k++) chk($sformatf("ovf_stamp%0d", k), log_q[4*k].data, k);
        end

        // Pop of the last word coincides with a capture at full.
        do_reset();
        for (int i = 0; i < 8; i++) cap(rnd_sample());
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && log_q.size() < 3; i++) step();
        chk("fp_at_last", bus.out_last, 1'b1);
        cap(rnd_sample());
        chk("fp_dropped", dropped, 16'd1);
        chk("fp_overflow", overflow, 1'b1);
        drain(200);
        chk("fp_frames", frames(), 8);

        // Back-to-back frames with no idle gap.
        do_reset();
        bus.out_ready = 1'b1;
        step();
        step();
        for (int i = 0; i < 3; i++) cap(rnd_sample());
        drain(100);
        chk("b2b_len", log_q.size(), 12);
        if (log_q.size() == 12) begin
            chk("b2b_span", acc_cyc[11] - acc_cyc[0], 11);
            for (int k = 0; k < 3; k++) chk($sformatf("b2b_stamp%0d", k), log_q[4*k].data, k + 2);
        end

        // Repeated samples: A, A, B, A.
        do_reset();
        bus.out_ready = 1'b1;
        sa = rnd_sample();
        sb = ~sa;
        cap(sa);
        cap(sa);
        cap(sb);
        cap(sa);
        drain(100);
`ifdef TRACE_RECORDER_DEDUP_EN
        chk("dedup_frames", frames(), 3);
`else
        chk("dedup_frames", frames(), 4);
`endif
        chk("dedup_dropped", dropped, 16'd0);

        // Random traffic with a mid-run asynchronous reset.
        do_reset();
        sc = rnd_sample();
        for (int c = 0; c < 4000; c++) begin
            int r;
            record_en    = ($urandom_range(0, 3) != 0);
            sample_valid = ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 3);
            sample = (r == 0) ? sa : (r == 1) ? sb : (r == 2) ? sc : rnd_sample();
            bus.out_ready = ((c / 500) % 2 == 0) ? ($urandom_range(0, 7) == 0)
                                                 : ($urandom_range(0, 3) != 0);
            if (c == 2000) begin
                @(posedge clock);
                #2;
                reset = 1'b0;
                #2;
                reset = 1'b1;
                @(negedge clock);
            end else begin
                step();
            end
        end
        record_en    = 1'b0;
        sample_valid = 1'b0;
        drain(500);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/trace_recorder.md
Name: trace_recorder

Overview:
- Record-side counterpart of the cycle-replay harness: captures the DUT I/O sample vector on chosen cycles and timestamps each capture with the cycle count.
- Buffers captures in a small FIFO and streams them to the host as fixed-length word frames over a ready/valid interface.
- The host rebuilds a replay trace from these frames.

Parameters:
- SAMPLE_W, 96, width of captured sample vector (>=1)
- OUT_W, 32, output word width; also cycle-stamp width
- DEPTH, 8, FIFO entries; power of two, >=2
- NW, derived = ceil(SAMPLE_W/OUT_W); payload words per frame (3 at defaults)

Ports:
- clock  input  1  single clock, all logic on posedge
- reset  input  1  asynchronous, active-low reset
- record_en  input  1  capture enable
- sample_valid  input  1  sample is capturable this cycle
- sample  input  SAMPLE_W  DUT I/O snapshot
- out_valid  output  1  out_data holds a valid frame word
- out_ready  input  1  host accepts word
- out_data  output  OUT_W  frame word
- out_last  output  1  final word of frame
- dropped  output  16  captures lost to full FIFO, saturating
- overflow  output  1  sticky, set on first drop
- empty  output  1  FIFO empty and serializer idle

Behaviour:
- Reset (reset==0, async):
  - cycle counter=0, FIFO cleared, state=IDLE.
  - out_valid=0, out_data=0, out_last=0, dropped=0, overflow=0, empty=1.
- Cycle counter:
  - OUT_W bits; increments every clock while reset==1.
  - Wraps 2^OUT_W-1 -> 0 silently.
- Capture:
  - Occurs on a posedge where record_en&&sample_valid.
  - Pushes {cycle counter value of that cycle, sample} into the FIFO.
  - The first cycle after reset release carries stamp 0.
- Full check:
  - Uses the registered occupancy before any same-cycle pop.
  - Capture while occupancy==DEPTH: entry discarded; dropped += 1 (saturates at 0xFFFF); overflow <= 1.
  - Simultaneous pop at full still drops the new capture.
- Frame format: word 0 = stamp, words 1..NW = sample chunks.
  - LSB chunk first.
  - The final chunk is zero-padded above SAMPLE_W.
  - out_last=1 only on word NW.
- Serializer FSM:
  - IDLE: if FIFO non-empty -> HDR. Head entry is presented in place, no extra copy. out_valid asserts the cycle after the entry becomes visible (1-cycle push-to-valid minimum latency).
  - HDR: out_data=stamp, out_valid=1. On out_valid&&out_ready -> DATA with idx=0.
  - DATA: out_data=chunk[idx]. On handshake: if idx==NW-1, pop FIFO, then go to HDR if another entry remains (back-to-back, no bubble), else IDLE. Otherwise idx+1.
- Handshake rules:
  - While out_valid==1 && out_ready==0, out_data and out_last are held stable.
  - out_valid never drops without a handshake.
- Frames are atomic:
  - Deasserting record_en mid-frame does not truncate the frame.
  - It only stops new captures.
- empty = (occupancy==0) && state==IDLE.
- Async reset mid-frame discards the partial frame. The host treats the reset edge as a trace boundary.

Optional Feature:
- Macro TRACE_RECORDER_DEDUP_EN.
- When defined:
  - A SAMPLE_W register holds the last captured sample, plus a "have_prev" bit that is cleared by reset.
  - A capture is pushed only if have_prev==0 or sample != last captured sample. Both the stored sample and have_prev update only on an actual push.
  - Suppressed captures are not counted in dropped.
- When undefined: every qualifying capture is pushed. No comparison register is built.

Test Plan:
- Single capture: reset release, cycle 5 sample=0x0000_0003_0000_0002_0000_0001, out_ready=1 -> words 0x5, 0x1, 0x2, 0x3; out_last only on 4th; then empty=1.
- Backpressure: out_ready=0 for 10 cycles during DATA idx=1 -> out_data stays the word-2 value, out_valid stays 1; frame resumes intact when out_ready=1.
- Overflow:
  - Stimulus: out_ready=0, capture 10 consecutive cycles with DEPTH=8.
  - Response: dropped=2, overflow=1. After draining, exactly 8 frames appear, stamps consecutive.
- Full+pop same cycle: fill to 8, then assert out_ready so the pop lands with capture 9 -> capture 9 dropped, dropped=1.
- Back-to-back: 3 captures at cycles 2,3,4, out_ready=1 -> 12 consecutive valid words, no idle gap, stamps 2,3,4.
- Dedup (TRACE_RECORDER_DEDUP_EN): samples A,A,B,A on 4 cycles -> 3 frames (A,B,A); dropped=0. Without macro -> 4 frames.
